uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 127 ++++++++++++
 tb/tb_uart_rx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: start/8 data (LSB first)/optional even parity/stop, mid-bit sampling.
// Define UART_RX_SYNC_EN to pass rx_in through a two-flop synchronizer first.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       parity_enable,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       busy
);
    localparam int CW = 10;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic rx;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], rx_in};
    end
    assign rx = sync_q[1];
`else
    assign rx = rx_in;
`endif

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      idx, idx_n;
    logic [7:0]      shreg, shreg_n;
    logic            par_en_q, par_en_n;
    logic            par_err_q, par_err_n;
    logic            rx_prev;
    logic            load, ferr;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        idx_n     = idx;
        shreg_n   = shreg;
        par_en_n  = par_en_q;
        par_err_n = par_err_q;
        load      = 1'b0;
        ferr      = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                // Falling edge only: a line held low after a bad stop bit is ignored
                if (rx_prev && !rx) begin
                    state_n   = START;
                    par_en_n  = parity_enable;
                    par_err_n = 1'b0;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_n   = '0;
                    idx_n   = 3'd0;
                    state_n = rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_n       = '0;
                    shreg_n[idx] = rx;
                    idx_n       = idx + 3'd1;
                    if (idx == 3'd7) state_n = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (cnt == FULL_M1) begin
                    cnt_n     = '0;
                    par_err_n = (^shreg) ^ rx;
                    state_n   = STOP;
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (rx) load = 1'b1;
                    else    ferr = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= 3'd0;
            shreg         <= 8'h00;
            par_en_q      <= 1'b0;
            par_err_q     <= 1'b0;
            rx_prev       <= 1'b1;
            data_out      <= 8'h00;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            idx           <= idx_n;
            shreg         <= shreg_n;
            par_en_q      <= par_en_n;
            par_err_q     <= par_err_n;
            rx_prev       <= rx;
            data_valid    <= load;
            parity_error  <= load & par_err_q;
            framing_error <= ferr;
            if (load) data_out <= shreg;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=4; latencies shift by 2 with UART_RX_SYNC_EN.
module tb_uart_rx;
    localparam int CPB = 4;
`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       parity_enable = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, parity_error, framing_error, busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic       clr = 1'b0;
    int         nvalid, nframe, nperr;
    logic [7:0] vdata [4];
    int         vcyc  [4];
    logic       vperr [4];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .parity_enable(parity_enable),
        .data_out(data_out), .data_valid(data_valid), .parity_error(parity_error),
        .framing_error(framing_error), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled on the falling edge
    always @(negedge clk) begin
        if (clr) begin
            nvalid <= 0; nframe <= 0; nperr <= 0;
        end else begin
            if (data_valid) begin
                if (nvalid < 4) begin
                    vdata[nvalid] <= data_out;
                    vcyc[nvalid]  <= cyc;
                    vperr[nvalid] <= parity_error;
                end
                nvalid <= nvalid + 1;
            end
            if (framing_error) nframe <= nframe + 1;
            if (parity_error)  nperr  <= nperr + 1;
        end
    end

    task automatic clr_mon;
        @(posedge clk); clr = 1'b1;
        @(posedge clk); clr = 1'b0;
        @(negedge clk);
    endtask

    // Caller must be at a falling edge; c is the cycle at which the start bit is driven
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit,
                              input logic stopb, input logic flip, output int c);
        c = cyc;
        parity_enable = pe;
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            if (flip && i == 1) parity_enable = ~pe;
            repeat (CPB) @(negedge clk);
        end
        if (pe) begin
            rx_in = pbit;
            repeat (CPB) @(negedge clk);
        end
        rx_in = stopb;
        repeat (CPB) @(negedge clk);
        rx_in = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_out); end
        checks++; if ({data_valid, parity_error, framing_error} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {data_valid, parity_error, framing_error}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic;
        int c;
        clr_mon();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, c);
        repeat (6) @(negedge clk);
        checks++; if (nvalid !== 1) begin errors++; $display("FAIL a5_count got %0d want 1", nvalid); end
        checks++; if (vdata[0] !== 8'hA5) begin errors++; $display("FAIL a5_data got %h want a5", vdata[0]); end
        checks++; if (vcyc[0] !== c + 39 + LAT) begin errors++; $display("FAIL a5_latency got %0d want %0d", vcyc[0], c + 39 + LAT); end
        checks++; if (nperr !== 0 || nframe !== 0) begin errors++; $display("FAIL a5_errflags got perr=%0d ferr=%0d want 0 0", nperr, nframe); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL a5_hold got %h want a5", data_out); end
    endtask

    task automatic test_parity;
        int c;
        clr_mon();
        // parity_enable toggles mid-frame; the latched value must be used
        send_frame(8'hEA, 1'b1, 1'b1, 1'b1, 1'b1, c);
        repeat (6) @(negedge clk);
        checks++; if (nvalid !== 1 || vdata[0] !== 8'hEA) begin errors++; $display("FAIL par_ok_data got n=%0d d=%h want 1 ea", nvalid, vdata[0]); end
        checks++; if (nperr !== 0) begin errors++; $display("FAIL par_ok_perr got %0d want 0", nperr); end
        checks++; if (vcyc[0] !== c + 43 + LAT) begin errors++; $display("FAIL par_ok_latency got %0d want %0d", vcyc[0], c + 43 + LAT); end
        clr_mon();
        send_frame(8'hEA, 1'b1, 1'b0, 1'b1, 1'b0, c);
        repeat (6) @(negedge clk);
        checks++; if (nvalid !== 1 || nperr !== 1) begin errors++; $display("FAIL par_bad_count got v=%0d p=%0d want 1 1", nvalid, nperr); end
        checks++; if (vperr[0] !== 1'b1) begin errors++; $display("FAIL par_bad_coincident got %b want 1", vperr[0]); end
        parity_enable = 1'b0;
    endtask

    task automatic test_framing;
        int c;
        clr_mon();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, c);
        repeat (6) @(negedge clk);
        checks++; if (nframe !== 1) begin errors++; $display("FAIL frm_count got %0d want 1", nframe); end
        checks++; if (nvalid !== 0) begin errors++; $display("FAIL frm_valid got %0d want 0", nvalid); end
        checks++; if (data_out !== 8'hEA) begin errors++; $display("FAIL frm_hold got %h want ea", data_out); end
    endtask

    task automatic test_glitch;
        clr_mon();
        rx_in = 1'b0;
        @(negedge clk); rx_in = 1'b1;
        repeat (LAT) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_start got busy=%b want 1", busy); end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got busy=%b want 0", busy); end
        repeat (10) @(negedge clk);
        checks++; if (nvalid + nframe + nperr !== 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", nvalid + nframe + nperr); end
    endtask

    task automatic test_reset_mid;
        int c;
        clr_mon();
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_in = 1'b1;
        repeat (4 * CPB + 1) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (data_out !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state got d=%h busy=%b want 00 0", data_out, busy); end
        repeat (40) @(negedge clk);
        send_frame(8'h19, 1'b0, 1'b0, 1'b1, 1'b0, c);
        repeat (6) @(negedge clk);
        checks++; if (nvalid !== 1 || vdata[0] !== 8'h19) begin errors++; $display("FAIL rstmid_data got n=%0d d=%h want 1 19", nvalid, vdata[0]); end
    endtask

    task automatic test_back_to_back;
        int c1, c2;
        clr_mon();
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, c1);
        send_frame(8'h19, 1'b0, 1'b0, 1'b1, 1'b0, c2);
        repeat (6) @(negedge clk);
        checks++; if (nvalid !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", nvalid); end
        checks++; if (vdata[0] !== 8'h55 || vdata[1] !== 8'h19) begin errors++; $display("FAIL b2b_data got %h %h want 55 19", vdata[0], vdata[1]); end
        checks++; if (vcyc[0] !== c1 + 39 + LAT || vcyc[1] !== c2 + 39 + LAT) begin errors++; $display("FAIL b2b_latency got %0d %0d want %0d %0d", vcyc[0], vcyc[1], c1 + 39 + LAT, c2 + 39 + LAT); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
